// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG entropy collector.
// The adaptive proportion test is built only when TRNG_APT_EN is defined.
package trng_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        ALARM  = 2'd2
    } trng_state_t;

    localparam int FAIL_RCT = 0;
    localparam int FAIL_APT = 1;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_DECIM      = 4;
    localparam int DEF_WARMUP     = 64;
    localparam int DEF_RCT_CUTOFF = 34;
    localparam int DEF_APT_W      = 512;
    localparam int DEF_APT_CUTOFF = 325;

endpackage

// File: rtl/trng_health_test.sv
// Continuous health tests on raw samples: repetition count, plus the adaptive
// proportion test when TRNG_APT_EN is defined. Fail outputs are same-cycle pulses.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_W      = DEF_APT_W,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic sample,
    input  logic restart,
    output logic rct_fail,
    output logic apt_fail
);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

    logic [RCT_W-1:0] rct_cnt_reg;
    logic             prev_reg;
    logic             rct_repeat;

    // A zero count marks "no previous sample yet", so the first sample after restart counts as 1.
    assign rct_repeat = (rct_cnt_reg != '0) && (sample == prev_reg);
    assign rct_fail   = strobe && rct_repeat && (rct_cnt_reg == RCT_W'(RCT_CUTOFF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_cnt_reg <= '0;
            prev_reg    <= 1'b0;
        end else if (restart) begin
            rct_cnt_reg <= '0;
        end else if (strobe) begin
            prev_reg    <= sample;
            rct_cnt_reg <= rct_repeat ? rct_cnt_reg + 1'b1 : RCT_W'(1);
        end
    end

`ifdef TRNG_APT_EN
    localparam int WIN_W  = (APT_W > 1) ? $clog2(APT_W) : 1;
    localparam int ONES_W = $clog2(APT_W + 1);

    logic [WIN_W-1:0]  win_cnt_reg;
    logic [ONES_W-1:0] ones_reg;
    logic [ONES_W-1:0] ones_total;
    logic              win_end;

    assign ones_total = ones_reg + ONES_W'(sample);
    assign win_end    = (win_cnt_reg == WIN_W'(APT_W - 1));
    assign apt_fail   = strobe && win_end &&
                        ((ones_total > ONES_W'(APT_CUTOFF)) ||
                         (ones_total < ONES_W'(APT_W - APT_CUTOFF)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_reg <= '0;
            ones_reg    <= '0;
        end else if (restart) begin
            win_cnt_reg <= '0;
            ones_reg    <= '0;
        end else if (strobe) begin
            if (win_end) begin
                win_cnt_reg <= '0;
                ones_reg    <= '0;
            end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                ones_reg    <= ones_total;
            end
        end
    end
`else
    assign apt_fail = 1'b0;
`endif

endmodule

// File: rtl/trng_collector.sv
// Decimates the serial entropy stream, discards warm-up samples, health-tests and packs
// samples into words on a valid/ready port. TRNG_APT_EN enables the proportion test.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int DECIM      = DEF_DECIM,
    parameter int WARMUP     = DEF_WARMUP,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_W      = DEF_APT_W,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              alarm_clr,
    output logic [WORD_W-1:0] rng_data,
    output logic              rng_valid,
    input  logic              rng_ready,
    output logic              alarm,
    output logic [1:0]        fail_code,
    output logic              overrun
);
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    trng_state_t       state_reg;
    trng_state_t       state_next;
    logic [DCNT_W-1:0] dcnt_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [BCNT_W-1:0] bcnt_reg;
    logic [WORD_W-1:0] shift_reg;
    logic              strobe;
    logic              run_strobe;
    logic              restart;
    logic              rct_fail;
    logic              apt_fail;
    logic              any_fail;
    logic              word_done;
    logic              can_load;
    logic              clr_event;

    assign strobe     = (dcnt_reg == DCNT_W'(DECIM - 1));
    assign run_strobe = strobe && (state_reg == trng_pkg::RUN);
    assign any_fail   = rct_fail || apt_fail;
    assign word_done  = run_strobe && (bcnt_reg == BCNT_W'(WORD_W - 1));
    assign can_load   = !rng_valid || rng_ready;
    assign clr_event  = (state_reg == trng_pkg::ALARM) && alarm_clr;

    trng_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_W      (APT_W),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk      (clk),
        .rst      (rst),
        .strobe   (run_strobe),
        .sample   (bit_in),
        .restart  (restart),
        .rct_fail (rct_fail),
        .apt_fail (apt_fail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= trng_pkg::WARMUP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            trng_pkg::WARMUP: if (strobe && (wcnt_reg == WCNT_W'(WARMUP - 1))) state_next = trng_pkg::RUN;
            trng_pkg::RUN:    if (run_strobe && any_fail) state_next = trng_pkg::ALARM;
            trng_pkg::ALARM:  if (alarm_clr) state_next = trng_pkg::WARMUP;
            default:          state_next = trng_pkg::WARMUP;
        endcase
    end

    always_comb begin
        alarm   = (state_reg == trng_pkg::ALARM);
        restart = (state_reg != trng_pkg::RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_reg <= '0;
        end else begin
            dcnt_reg <= strobe ? '0 : dcnt_reg + 1'b1;
        end
    end

    // Warm-up count is parked at zero outside WARMUP so every entry restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg <= '0;
        end else if (state_reg != trng_pkg::WARMUP) begin
            wcnt_reg <= '0;
        end else if (strobe) begin
            wcnt_reg <= (wcnt_reg == WCNT_W'(WARMUP - 1)) ? '0 : wcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_code <= 2'b00;
            overrun   <= 1'b0;
        end else if (clr_event) begin
            fail_code <= 2'b00;
            overrun   <= 1'b0;
        end else begin
            if (rct_fail) fail_code[FAIL_RCT] <= 1'b1;
            if (apt_fail) fail_code[FAIL_APT] <= 1'b1;
            if (word_done && !any_fail && !can_load) overrun <= 1'b1;
        end
    end

    // New samples enter at the MSB, so after WORD_W shifts the oldest sits in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bcnt_reg  <= '0;
            rng_data  <= '0;
            rng_valid <= 1'b0;
        end else if (run_strobe && any_fail) begin
            shift_reg <= '0;
            bcnt_reg  <= '0;
            rng_data  <= '0;
            rng_valid <= 1'b0;
        end else begin
            if (rng_valid && rng_ready) rng_valid <= 1'b0;
            if (word_done) begin
                if (can_load) begin
                    rng_data  <= {bit_in, shift_reg[WORD_W-1:1]};
                    rng_valid <= 1'b1;
                    bcnt_reg  <= '0;
                    shift_reg <= '0;
                end
            end else if (run_strobe) begin
                shift_reg <= {bit_in, shift_reg[WORD_W-1:1]};
                bcnt_reg  <= bcnt_reg + 1'b1;
            end
        end
    end

endmodule
